// File: rtl/inst_mem_loader_if.sv
// Byte-stream and instruction-memory write bus for inst_mem_loader.
//   in_valid / in_data / in_ready : host byte link, transfer on valid && ready
//   mem_write_enable / mem_write_addr / mem_write_data : InstMem write port
// modport slave  : the loader side (consumes bytes, drives memory writes)
// modport master : the host/memory side
interface inst_mem_loader_if #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned INST_W = 32
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_write_enable;
    logic [ADDR_W-1:0] mem_write_addr;
    logic [INST_W-1:0] mem_write_data;

    modport master (
        output in_valid, in_data,
        input  in_ready, mem_write_enable, mem_write_addr, mem_write_data
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, mem_write_enable, mem_write_addr, mem_write_data
    );
endinterface

// File: rtl/inst_mem_loader.sv
// Boot-time instruction-memory writer.
// Receives a frame {LEN_LO, LEN_HI, N*4 little-endian payload bytes, XOR
// checksum} over the byte link, writes each assembled word to consecutive
// word addresses starting at 0, then verifies the checksum.
//   clk, rst  : clock, synchronous active-high reset
//   start     : one-cycle pulse, begins a load when idle
//   bus       : byte link + InstMem write port (slave modport)
//   cpu_hold  : holds the processor until a load completes successfully
//   done      : load finished with good checksum (held until next start)
//   error     : 0 none, 1 length exceeds DEPTH, 2 checksum mismatch
module inst_mem_loader #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned INST_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    inst_mem_loader_if.slave   bus,
    output logic               cpu_hold,
    output logic               done,
    output logic [1:0]         error
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        CHECK
    } state_t;

    state_t      state, state_next;
    logic        in_ready;
    logic        hs;
    logic [15:0] len;
    logic [15:0] len_full;
    logic [15:0] word_cnt;
    logic [1:0]  byte_cnt;
    logic [23:0] word_buf;
    logic [7:0]  csum;
    logic        oversize;
    logic        last_word;

    assign bus.in_ready = in_ready;
    assign hs           = bus.in_valid && in_ready;
    // Length as it becomes complete on the LEN_HI handshake.
    assign len_full     = {bus.in_data, len[7:0]};
    assign oversize     = 32'(len_full) > DEPTH;
    assign last_word    = (word_cnt + 16'd1) == len;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_next = LEN_LO;
            end
            LEN_LO: begin
                in_ready = 1'b1;
                if (hs) state_next = LEN_HI;
            end
            LEN_HI: begin
                in_ready = 1'b1;
                if (hs) begin
                    if (oversize)              state_next = IDLE;
                    else if (len_full == '0)   state_next = CHECK;
                    else                       state_next = DATA;
                end
            end
            DATA: begin
                in_ready = 1'b1;
                if (hs && byte_cnt == 2'd3 && last_word) state_next = CHECK;
            end
            CHECK: begin
                in_ready = 1'b1;
                if (hs) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.mem_write_enable <= 1'b0;
            bus.mem_write_addr   <= '0;
            bus.mem_write_data   <= '0;
            cpu_hold             <= 1'b1;
            done                 <= 1'b0;
            error                <= 2'd0;
            len                  <= '0;
            word_cnt             <= '0;
            byte_cnt             <= '0;
            word_buf             <= '0;
            csum                 <= '0;
        end else begin
            bus.mem_write_enable <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        done     <= 1'b0;
                        error    <= 2'd0;
                        csum     <= '0;
                        word_cnt <= '0;
                        byte_cnt <= '0;
                        cpu_hold <= 1'b1;
                    end
                end
                LEN_LO: begin
                    if (hs) len[7:0] <= bus.in_data;
                end
                LEN_HI: begin
                    if (hs) begin
                        len[15:8] <= bus.in_data;
                        if (oversize) error <= 2'd1;
                    end
                end
                DATA: begin
                    if (hs) begin
                        csum     <= csum ^ bus.in_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        case (byte_cnt)
                            2'd0: word_buf[7:0]   <= bus.in_data;
                            2'd1: word_buf[15:8]  <= bus.in_data;
                            2'd2: word_buf[23:16] <= bus.in_data;
                            default: begin
                                // Top byte goes straight to the write port, so the
                                // strobe appears the cycle after the 4th byte.
                                bus.mem_write_enable <= 1'b1;
                                bus.mem_write_addr   <= ADDR_W'(word_cnt);
                                bus.mem_write_data   <= {bus.in_data, word_buf};
                                word_cnt             <= word_cnt + 16'd1;
                            end
                        endcase
                    end
                end
                CHECK: begin
                    if (hs) begin
                        if (bus.in_data == csum) begin
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            error    <= 2'd2;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_inst_mem_loader.sv
// Self-checking bench for inst_mem_loader (DEPTH = 32).
module tb_inst_mem_loader;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DEPTH  = 32;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       cpu_hold;
    logic       done;
    logic [1:0] error;

    inst_mem_loader_if #(.ADDR_W(ADDR_W), .INST_W(32)) bus ();

    inst_mem_loader #(.ADDR_W(ADDR_W), .INST_W(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bus      (bus),
        .cpu_hold (cpu_hold),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        int unsigned cyc;
    } wr_t;

    wr_t         wr_q[$];
    int unsigned hs_q[$];

    // hs_q holds the index of the edge at which each byte transfers; a write
    // seen with cyc == k was strobed in the cycle right after edge k.
    always @(negedge clk) begin
        if (bus.in_valid && bus.in_ready) hs_q.push_back(cyc + 1);
        if (bus.mem_write_enable) wr_q.push_back('{bus.mem_write_addr, bus.mem_write_data, cyc});
    end

    int unsigned checks = 0;
    int unsigned errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Expected outcome of the current frame.
    logic [31:0] exp_q[$];
    bit          exp_done;
    logic [1:0]  exp_err;

    function automatic void model(input logic [7:0] fr[$]);
        int unsigned n;
        logic [7:0]  cs;
        logic [31:0] w;
        exp_q.delete();
        n = int'(fr[0]) + 256 * int'(fr[1]);
        if (n > DEPTH) begin
            exp_done = 0;
            exp_err  = 2'd1;
            return;
        end
        cs = 8'h00;
        for (int j = 0; j < int'(n); j++) begin
            w = 32'h0;
            for (int k = 0; k < 4; k++) begin
                w  = w | (32'(fr[2 + 4 * j + k]) << (8 * k));
                cs = cs ^ fr[2 + 4 * j + k];
            end
            exp_q.push_back(w);
        end
        exp_done = (fr[2 + 4 * n] == cs);
        exp_err  = exp_done ? 2'd0 : 2'd2;
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int unsigned gap_max);
        int unsigned g;
        int unsigned t;
        g = (gap_max == 0) ? 0 : $urandom_range(gap_max, 0);
        repeat (g) begin @(posedge clk); #1; end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        t = 0;
        while (!bus.in_ready && t < 50) begin @(posedge clk); #1; t++; end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout actual=0 required=1");
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
    endtask

    task automatic send_all(input logic [7:0] fr[$], input int unsigned gap_max);
        foreach (fr[i]) send_byte(fr[i], gap_max);
    endtask

    task automatic run_frame(input string tag, input logic [7:0] fr[$],
                             input int unsigned gap_max, input bit stress);
        int unsigned t;
        hs_q.delete();
        wr_q.delete();
        pulse_start();
        chk({tag, "_hold_after_start"}, 32'(cpu_hold), 32'd1);
        chk({tag, "_done_cleared"}, 32'(done), 32'd0);
        chk({tag, "_err_cleared"}, 32'(error), 32'd0);
        if (stress) begin
            fork
                send_all(fr, gap_max);
                begin
                    t = 0;
                    while (hs_q.size() < 4 && t < 500) begin @(posedge clk); #1; t++; end
                    pulse_start();
                end
            join
        end else begin
            send_all(fr, gap_max);
        end
        repeat (3) begin @(posedge clk); #1; end
        chk({tag, "_done"}, 32'(done), 32'(exp_done));
        chk({tag, "_error"}, 32'(error), 32'(exp_err));
        chk({tag, "_cpu_hold"}, 32'(cpu_hold), exp_done ? 32'd0 : 32'd1);
        chk({tag, "_in_ready_idle"}, 32'(bus.in_ready), 32'd0);
        chk({tag, "_nwrites"}, wr_q.size(), exp_q.size());
        for (int j = 0; j < exp_q.size() && j < wr_q.size(); j++) begin
            chk($sformatf("%s_addr%0d", tag, j), 32'(wr_q[j].addr), 32'(j));
            chk($sformatf("%s_data%0d", tag, j), wr_q[j].data, exp_q[j]);
            if (5 + 4 * j < hs_q.size())
                chk($sformatf("%s_lat%0d", tag, j), wr_q[j].cyc, hs_q[5 + 4 * j]);
        end
    endtask

    typedef struct {
        string       name;
        int unsigned nb;
        logic [7:0]  b[12];
        bit          d;
        logic [1:0]  err;
        int unsigned nwr;
        logic [31:0] w0;
        logic [31:0] w1;
    } vec_t;

    vec_t        vecs[5];
    logic [7:0]  fr[$];
    logic [7:0]  good[$];

    initial begin
        #5000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{"good", 11, '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2A, 8'h00},
                    1, 2'd0, 2, 32'h12345678, 32'hDEADBEEF};
        vecs[1] = '{"badcs", 11, '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2B, 8'h00},
                    0, 2'd2, 2, 32'h12345678, 32'hDEADBEEF};
        vecs[2] = '{"empty", 3, '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                    1, 2'd0, 0, 32'h0, 32'h0};
        vecs[3] = '{"oversize", 2, '{8'h21, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                    0, 2'd1, 0, 32'h0, 32'h0};
        vecs[4] = '{"oneword", 7, '{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                    1, 2'd0, 1, 32'h04030201, 32'h0};

        rst          = 1'b1;
        start        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_we", 32'(bus.mem_write_enable), 32'd0);
        chk("rst_addr", 32'(bus.mem_write_addr), 32'd0);
        chk("rst_data", bus.mem_write_data, 32'd0);
        chk("rst_hold", 32'(cpu_hold), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);

        // Directed table
        foreach (vecs[v]) begin
            fr.delete();
            for (int i = 0; i < int'(vecs[v].nb); i++) fr.push_back(vecs[v].b[i]);
            exp_q.delete();
            if (vecs[v].nwr > 0) exp_q.push_back(vecs[v].w0);
            if (vecs[v].nwr > 1) exp_q.push_back(vecs[v].w1);
            exp_done = vecs[v].d;
            exp_err  = vecs[v].err;
            run_frame(vecs[v].name, fr, 0, 0);
        end

        // Bytes offered while idle must not be consumed or change status
        hs_q.delete();
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h55;
        repeat (3) begin @(posedge clk); #1; end
        bus.in_valid = 1'b0;
        chk("idle_no_consume", hs_q.size(), 32'd0);
        chk("idle_done_held", 32'(done), 32'd1);
        chk("idle_ready", 32'(bus.in_ready), 32'd0);

        // Reset in the middle of DATA, two bytes into the first word
        good = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2A};
        wr_q.delete();
        pulse_start();
        send_all('{8'h02, 8'h00, 8'hAA, 8'hBB}, 0);
        rst = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk("midrst_writes", wr_q.size(), 32'd0);
        chk("midrst_hold", 32'(cpu_hold), 32'd1);
        chk("midrst_ready", 32'(bus.in_ready), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_error", 32'(error), 32'd0);
        model(good);
        run_frame("after_rst", good, 0, 0);

        // Gapped handshake with a start pulse landing in DATA
        model(good);
        run_frame("stress", good, 3, 1);

        // Randomised frames, including N = DEPTH and N = DEPTH + 1
        for (int it = 0; it < 30; it++) begin
            int unsigned n;
            logic [7:0]  cs;
            if (it == 0)                       n = DEPTH;
            else if (it == 1)                  n = DEPTH + 1;
            else if ($urandom_range(9, 0) == 0) n = $urandom_range(300, DEPTH + 1);
            else                               n = $urandom_range(5, 0);
            fr.delete();
            fr.push_back(8'(n));
            fr.push_back(8'(n >> 8));
            if (n <= DEPTH) begin
                cs = 8'h00;
                for (int i = 0; i < int'(4 * n); i++) begin
                    logic [7:0] b;
                    b  = 8'($urandom);
                    cs = cs ^ b;
                    fr.push_back(b);
                end
                if ($urandom_range(3, 0) == 0) cs = cs ^ 8'(1 << $urandom_range(7, 0));
                fr.push_back(cs);
            end
            model(fr);
            run_frame($sformatf("rand%0d", it), fr, $urandom_range(3, 0), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
